// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the two-digit seven-segment multiplexer.
//   state_t    - controller states
//   SEG_BLANK  - all segments off (active-low)
//   AN_*       - anode patterns (active-low)
//   SEG_TABLE  - hex to {g,f,e,d,c,b,a} active-low segment patterns
package seg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BLANK0 = 3'd1,
        SHOW0  = 3'd2,
        BLANK1 = 3'd3,
        SHOW1  = 3'd4
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [1:0] AN_OFF = 2'b11;
    localparam logic [1:0] AN_D0  = 2'b10;
    localparam logic [1:0] AN_D1  = 2'b01;

    // Entry [n] holds the pattern for hex digit n; listed from F down to 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: combinational hex to seven-segment decoder.
//   hex - 4-bit value to display
//   seg - segments {g,f,e,d,c,b,a}, active-low
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_mux_ctrl.sv
// seg_mux_ctrl: time-multiplexes one segment bus across two common-anode
// digits, with a blanking gap before every digit to prevent ghosting.
//   clk        - system clock
//   reset      - asynchronous active-low reset
//   en         - display enable; low forces IDLE on the next edge
//   s0, s1     - hex values for digit 0 / digit 1
//   seg        - segments {g,f,e,d,c,b,a}, active-low, registered
//   an         - anode enables, active-low, an[0] drives digit 0, registered
//   frame_tick - one-cycle pulse on the first BLANK0 cycle after a full frame
module seg_mux_ctrl
    import seg_pkg::*;
#(
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    // A single-cycle slot would give $clog2 of 0; keep at least one bit.
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       hold, hold_d;
    logic             tick_d;
    logic [6:0]       seg_d, seg_dec;
    logic [1:0]       an_d;

    // State, counter, hold and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hold       <= '0;
            seg        <= SEG_BLANK;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            hold       <= hold_d;
            seg        <= seg_d;
            an         <= an_d;
            frame_tick <= tick_d;
        end
    end

    // Next-state logic. hold is loaded on the edge that enters a SHOW state,
    // so the digit cannot change mid-slot.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would infer a latch.
        state_d = state;
        hold_d  = hold;
        tick_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE:   state_d = BLANK0;
                BLANK0: if (cnt == BLANK_LAST) begin
                            state_d = SHOW0;
                            hold_d  = s0;
                        end
                SHOW0:  if (cnt == DWELL_LAST) state_d = BLANK1;
                BLANK1: if (cnt == BLANK_LAST) begin
                            state_d = SHOW1;
                            hold_d  = s1;
                        end
                SHOW1:  if (cnt == DWELL_LAST) begin
                            state_d = BLANK0;
                            tick_d  = 1'b1;
                        end
                default: state_d = IDLE;
            endcase
        end
        // Every state entry restarts the slot count; IDLE never counts.
        if (state_d != state || state == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    // Decode the value hold will have after this edge, so the registered
    // segments line up with the registered state.
    seg_decoder u_dec (
        .hex (hold_d),
        .seg (seg_dec)
    );

    // Output logic: next values for the output registers.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        unique case (state_d)
            SHOW0: begin
                an_d  = AN_D0;
                seg_d = seg_dec;
            end
            SHOW1: begin
                an_d  = AN_D1;
                seg_d = seg_dec;
            end
            default: begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_seg_mux_ctrl.sv
module tb_seg_mux_ctrl;

    localparam int D = 4;
    localparam int B = 2;
    localparam int F = 2 * (B + D);

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       en_def;
    logic [3:0] s0, s1;
    logic [6:0] seg, seg_def;
    logic [1:0] an, an_def;
    logic       frame_tick, frame_tick_def;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [1:0] an;
        logic [6:0] seg;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: position within the current enabled run.
    bit         active = 1'b0;
    int         pos    = 0;
    logic [3:0] h0 = '0, h1 = '0;

    always #5 clk = ~clk;

    seg_mux_ctrl #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .s0         (s0),
        .s1         (s1),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    seg_mux_ctrl dut_def (
        .clk        (clk),
        .reset      (reset),
        .en         (en_def),
        .s0         (s0),
        .s1         (s1),
        .seg        (seg_def),
        .an         (an_def),
        .frame_tick (frame_tick_def)
    );

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Advance the reference model for one edge with the inputs seen at it.
    task automatic model_edge(input logic e, input logic [3:0] a, input logic [3:0] b);
        exp_t x;
        int   ph;
        x.an  = 2'b11;
        x.seg = 7'h7F;
        x.ft  = 1'b0;
        if (!e) begin
            active = 1'b0;
        end else begin
            if (!active) begin
                active = 1'b1;
                pos    = 0;
            end else begin
                pos++;
            end
            ph = pos % F;
            if (ph == B)         h0 = a;
            if (ph == 2 * B + D) h1 = b;
            if (ph >= B && ph < B + D) begin
                x.an  = 2'b10;
                x.seg = hex7(h0);
            end else if (ph >= 2 * B + D) begin
                x.an  = 2'b01;
                x.seg = hex7(h1);
            end
            x.ft = (pos > 0 && ph == 0);
        end
        exp_q.push_back(x);
    endtask

    // Drive inputs, take one edge, record the expectation, settle past the edge.
    task automatic step(input logic e, input logic [3:0] a, input logic [3:0] b);
        en = e;
        s0 = a;
        s1 = b;
        @(posedge clk);
        model_edge(e, a, b);
        #1;
    endtask

    function automatic int cur_ph();
        return active ? (pos % F) : -1;
    endfunction

    // Monitor: compare every cycle the DUT presents against the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("an", 32'(an), 32'(x.an));
                check("seg", 32'(seg), 32'(x.seg));
                check("frame_tick", 32'(frame_tick), 32'(x.ft));
                check("an_not_both_low", 32'(an != 2'b00), 32'd1);
            end
        end
    end

    initial begin
        int nb, nd;
        reset  = 1'b0;
        en     = 1'b1;
        en_def = 1'b0;
        s0     = 4'h3;
        s1     = 4'h0;

        // Reset held with enable active: outputs stay blank.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_an", 32'(an), 32'h3);
            check("rst_seg", 32'(seg), 32'h7F);
            check("rst_tick", 32'(frame_tick), 32'h0);
        end
        en    = 1'b0;
        reset = 1'b1;

        // Nominal frames: digit 0 = 0, digit 1 = 8.
        repeat (26) step(1'b1, 4'h0, 4'h8);

        // Input stability: change s0 on the 2nd SHOW0 cycle.
        for (int i = 0; i < 2 * F && cur_ph() != B + 1; i++) step(1'b1, 4'h3, 4'h8);
        repeat (F + 2) step(1'b1, 4'hA, 4'h8);

        // Enable drop on the 3rd SHOW1 cycle, then re-enable.
        for (int i = 0; i < 2 * F && cur_ph() != 2 * B + D + 2; i++) step(1'b1, 4'h5, 4'h6);
        step(1'b0, 4'h5, 4'h6);
        repeat (F) step(1'b1, 4'h5, 4'h6);

        // Decoder sweep across both digits.
        for (int v = 0; v < 16; v++) begin
            repeat (F) step(1'b1, 4'(v), 4'(15 - v));
        end

        // Asynchronous reset in the middle of SHOW0.
        for (int i = 0; i < 2 * F && cur_ph() != B + 1; i++) step(1'b1, 4'h7, 4'h2);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'h3);
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_tick", 32'(frame_tick), 32'h0);
        active = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (F) step(1'b1, 4'h7, 4'h2);

        // Randomised traffic with occasional enable drops.
        repeat (400) step(($urandom % 20) != 0, 4'($urandom), 4'($urandom));

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Default parameters: measure blank and dwell widths.
        en = 1'b0;
        @(posedge clk);
        #1;
        en_def = 1'b1;
        @(posedge clk);
        nb = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (an_def != 2'b11) break;
            nb++;
        end
        check("def_blank_width", 32'(nb), 32'd48);
        nd = 0;
        if (an_def == 2'b10) begin
            nd = 1;
            for (int i = 0; i < 30000; i++) begin
                @(negedge clk);
                if (an_def != 2'b10) break;
                nd++;
            end
        end
        check("def_dwell_width", 32'(nd), 32'd24000);
        en_def = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_mux_ctrl.md
# seg_mux_ctrl

Time-multiplexing controller that shares one hex-to-seven-segment decoder and one segment bus between two common-anode digits. It sits between the board switch inputs and the `seg`/anode pins in the top level. It alternates the digits at a parameterised dwell rate and inserts a blanking interval at every switch to prevent ghosting. Each digit's value is captured at the start of its slot so the pattern stays stable for the whole slot.

## Interface
- `DWELL_CYCLES`, default 24000: cycles each digit is lit (0.5 ms at 48 MHz). Must be ≥ 1.
- `BLANK_CYCLES`, default 48: all-off cycles before each digit (1 µs at 48 MHz). Must be ≥ 1.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: display enable, sampled on `clk`.
- `s0` input, 4 bits: hex value for digit 0.
- `s1` input, 4 bits: hex value for digit 1.
- `seg` output, 7 bits: segments {g,f,e,d,c,b,a}, active-low (1 = off).
- `an` output, 2 bits: anode enables, active-low; `an[0]` drives digit 0.
- `frame_tick` output, 1 bit: one-cycle pulse when a full two-digit frame completes.

## Operation
- The FSM has five states: IDLE, BLANK0, SHOW0, BLANK1, SHOW1.
- A single counter `cnt` is cleared on every state entry. It is sized `$clog2(max(DWELL_CYCLES,BLANK_CYCLES))`.
- State transitions:
  - IDLE → BLANK0 when `en` = 1.
  - BLANK0 → SHOW0 when `cnt` = BLANK_CYCLES−1. On this edge, `s0` is latched into `hold`.
  - SHOW0 → BLANK1 when `cnt` = DWELL_CYCLES−1.
  - BLANK1 → SHOW1 when `cnt` = BLANK_CYCLES−1. On this edge, `s1` is latched into `hold`.
  - SHOW1 → BLANK0 when `cnt` = DWELL_CYCLES−1. `frame_tick` is 1 for the first cycle of BLANK0 entered this way.
- `en` = 0 in any state forces IDLE on the next edge. This takes priority over all other transitions, and no `frame_tick` is generated.
- Outputs are a pure function of registered state and `hold`. There is no combinational path from `s0`, `s1` or `en` to any output.
  - IDLE, BLANK0, BLANK1: `an` = 2'b11, `seg` = 7'b1111111.
  - SHOW0: `an` = 2'b10, `seg` = decode(`hold`).
  - SHOW1: `an` = 2'b01, `seg` = decode(`hold`).
- Changes to `s0`/`s1` during a slot are ignored until that digit's next slot entry.
- Reset values: state IDLE, `cnt` 0, `hold` 0, `an` 2'b11, `seg` 7'b1111111, `frame_tick` 0.
- Asserting `reset` mid-slot blanks the outputs immediately, without waiting for a clock edge.

## Timing
- Exactly one state transition per edge at most; `an` never has both bits low.
- Frame period is 2·(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Slot lengths are exact: BLANK_CYCLES blank cycles, then DWELL_CYCLES lit cycles, with no off-by-one.
- Latency from an input change to visible display is at most 2·(BLANK_CYCLES+DWELL_CYCLES) cycles.
- IDLE exit latency: the first cycle of BLANK0 is the cycle after the edge that samples `en` = 1.
- Reset release: the FSM stays in IDLE until the first rising edge with `reset` = 1 and `en` = 1.

## Structure
- Package `seg_pkg` holds:
  - the `state_t` enum;
  - constant `SEG_BLANK` = 7'h7F;
  - constants `AN_OFF` = 2'b11, `AN_D0` = 2'b10, `AN_D1` = 2'b01;
  - the 16-entry hex segment table.
- Sub-module `seg_decoder`: combinational, 4-bit hex in, 7-bit active-low segments out. It uses the package table and is instantiated once. The top level reuses it in place of any per-digit decoder.
- `seg_mux_ctrl` contains only the FSM, `cnt`, `hold` and the output registers.

## Test plan
All scenarios use DWELL_CYCLES = 4 and BLANK_CYCLES = 2 unless noted.
- **Reset:** `reset` = 0 with `en` = 1 and `s0` = 4'h3 → `an` = 2'b11, `seg` = 7'h7F, `frame_tick` = 0. Asserting `reset` mid-SHOW0 blanks both outputs in the same time step.
- **Nominal frame:** `en` = 1, `s0` = 4'h0, `s1` = 4'h8 →
  - 2 cycles `an` = 11;
  - 4 cycles `an` = 10, `seg` = 7'b1000000;
  - 2 cycles blank;
  - 4 cycles `an` = 01, `seg` = 7'b0000000;
  - then `frame_tick` = 1 for exactly 1 cycle; pattern repeats every 12 cycles.
- **Input stability:** change `s0` from 4'h3 to 4'hA on the 2nd SHOW0 cycle → `seg` holds 7'b0110000 through the slot. The next SHOW0 shows 7'b0001000.
- **Enable drop:** drop `en` on the 3rd SHOW1 cycle →
  - the next cycle is IDLE, with blank outputs and no `frame_tick`;
  - re-raising `en` gives 2 blank cycles, then digit 0 (`an` = 10).
- **Decoder sweep:** sweep `s0`/`s1` through 4'h0–4'hF and check every lit slot against the package table (e.g. 4'hF → 7'b0001110). `an` must never be 2'b00 at any cycle.
- **Default parameters:** measure the SHOW0 width at 24000 cycles and the BLANK width at 48 cycles.
